// File: rtl/niosii_timer_pkg.sv
// Shared definitions for the Nios II interval timer bank:
// register offsets within a channel and the bit positions of CONTROL/STATUS fields.
package niosii_timer_pkg;

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_CONTROL = 3'd1,
        REG_PERIODL = 3'd2,
        REG_PERIODH = 3'd3,
        REG_SNAPL   = 3'd4,
        REG_SNAPH   = 3'd5
    } reg_e;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam int ST_TO     = 0;
    localparam int ST_RUN    = 1;

endpackage

// File: rtl/niosii_multi_interval_timer_if.sv
// Avalon-MM slave bundle for the timer bank; address is {channel, reg[2:0]}.
interface niosii_multi_interval_timer_if #(
    parameter int N_CHANNELS = 4
);
    logic [3+$clog2(N_CHANNELS)-1:0] address;
    logic                            chipselect;
    logic                            write_n;
    logic [15:0]                     writedata;
    logic [15:0]                     readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/niosii_timer_channel.sv
// One interval timer channel: down-counter with period reload, snapshot,
// RUN/CONT/ITO/TO state and the combinational read mux for its eight registers.
module niosii_timer_channel
    import niosii_timer_pkg::*;
#(
    parameter int          COUNTER_WIDTH  = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F,
    parameter bit          RESET_RUN      = 1'b1,
    parameter bit          RESET_CONT     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [2:0]  i_reg,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_irq
);

    localparam int CW = COUNTER_WIDTH;

    logic [CW-1:0] r_counter;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_snap;
    logic          r_run;
    logic          r_cont;
    logic          r_ito;
    logic          r_to;

    logic          w_timeout;
    logic [CW-1:0] w_period_new;

    assign w_timeout = r_run && (r_counter == '0);
    assign o_irq     = r_to & r_ito;

    // Period value after a PERIODL/PERIODH write; high bits beyond the counter are dropped.
    always_comb begin
        w_period_new = r_period;
        if (i_reg == REG_PERIODL)
            w_period_new[15:0] = i_wdata;
        else
            w_period_new[CW-1:16] = i_wdata[CW-17:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: period, counter and snapshot are plain registers, not a RAM, so they take a reset value.
            r_counter <= DEFAULT_PERIOD[CW-1:0];
            r_period  <= DEFAULT_PERIOD[CW-1:0];
            r_snap    <= '0;
            r_run     <= RESET_RUN;
            r_cont    <= RESET_CONT;
            r_ito     <= 1'b0;
            r_to      <= 1'b0;
        end else begin
            if (r_run) begin
                if (w_timeout) begin
                    r_counter <= r_period;
                    if (!r_cont)
                        r_run <= 1'b0;
                end else begin
                    r_counter <= r_counter - CW'(1);
                end
            end

            // A timeout in the same clk as a STATUS clear keeps TO set.
            if (w_timeout)
                r_to <= 1'b1;
            else if (i_we && i_reg == REG_STATUS)
                r_to <= 1'b0;

            // NOTE: non-blocking assignments later in this block override the counting above.
            if (i_we) begin
                case (i_reg)
                    REG_CONTROL: begin
                        r_ito  <= i_wdata[CTL_ITO];
                        r_cont <= i_wdata[CTL_CONT];
                        if (i_wdata[CTL_STOP])
                            r_run <= 1'b0;
                        else if (i_wdata[CTL_START])
                            r_run <= 1'b1;
                    end
                    REG_PERIODL, REG_PERIODH: begin
                        r_period  <= w_period_new;
                        r_counter <= w_period_new;
                        r_run     <= 1'b0;
                    end
                    REG_SNAPL: r_snap <= r_counter;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        o_rdata = '0;
        case (i_reg)
            REG_STATUS: begin
                o_rdata[ST_TO]  = r_to;
                o_rdata[ST_RUN] = r_run;
            end
            REG_CONTROL: begin
                o_rdata[CTL_ITO]  = r_ito;
                o_rdata[CTL_CONT] = r_cont;
            end
            REG_PERIODL: o_rdata = r_period[15:0];
            REG_PERIODH: o_rdata = 16'(r_period[CW-1:16]);
            REG_SNAPL:   o_rdata = r_snap[15:0];
            REG_SNAPH:   o_rdata = 16'(r_snap[CW-1:16]);
            default:     o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/niosii_multi_interval_timer.sv
// Avalon-MM bank of N independent interval timers: decodes the channel field,
// registers the selected channel's read data and combines the interrupts.
module niosii_multi_interval_timer
    import niosii_timer_pkg::*;
#(
    parameter int          N_CHANNELS     = 4,
    parameter int          COUNTER_WIDTH  = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F,
    parameter bit          RESET_RUN      = 1'b1,
    parameter bit          RESET_CONT     = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    niosii_multi_interval_timer_if.slave  avs,
    output logic [N_CHANNELS-1:0]         irq,
    output logic                          irq_any
);

    localparam int ADDR_W = 3 + $clog2(N_CHANNELS);

    logic              w_write;
    logic [ADDR_W-1:0] w_ch;
    logic [2:0]        w_reg;
    logic [N_CHANNELS-1:0] w_we;
    logic [15:0]       w_ch_rdata [N_CHANNELS];
    logic [15:0]       w_rdata;
    logic [15:0]       r_readdata;

    assign w_write = avs.chipselect & ~avs.write_n;
    assign w_ch    = avs.address >> 3;
    assign w_reg   = avs.address[2:0];

    // Channel indices with no instance match nothing: reads return 0, writes vanish.
    always_comb begin
        w_we    = '0;
        w_rdata = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (w_ch == ADDR_W'(c)) begin
                w_we[c] = w_write;
                w_rdata = w_ch_rdata[c];
            end
        end
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        niosii_timer_channel #(
            .COUNTER_WIDTH  (COUNTER_WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .RESET_RUN      (RESET_RUN),
            .RESET_CONT     (RESET_CONT)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_we[c]),
            .i_reg   (w_reg),
            .i_wdata (avs.writedata),
            .o_rdata (w_ch_rdata[c]),
            .o_irq   (irq[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_readdata <= '0;
        else
            r_readdata <= w_rdata;
    end

    assign avs.readdata = r_readdata;
    assign irq_any      = |irq;

endmodule

// File: tb/tb_niosii_multi_interval_timer.sv
// Directed bench for the interval timer bank: a 4-channel instance with a short
// default period plus a 3-channel, 20-bit instance for unmapped-channel and width corners.
module tb_niosii_multi_interval_timer;
    import niosii_timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] irq;
    logic       irq_any;
    logic [2:0] irq2;
    logic       irq_any2;

    int n_tests = 0;
    int n_fail  = 0;

    niosii_multi_interval_timer_if #(.N_CHANNELS(4)) u_if ();
    niosii_multi_interval_timer_if #(.N_CHANNELS(3)) u_if2 ();

    niosii_multi_interval_timer #(
        .N_CHANNELS(4), .COUNTER_WIDTH(32), .DEFAULT_PERIOD(32'd49),
        .RESET_RUN(1'b1), .RESET_CONT(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .avs(u_if.slave), .irq(irq), .irq_any(irq_any)
    );

    niosii_multi_interval_timer #(
        .N_CHANNELS(3), .COUNTER_WIDTH(20), .DEFAULT_PERIOD(32'h1869F),
        .RESET_RUN(1'b1), .RESET_CONT(1'b1)
    ) u_dut2 (
        .clk(clk), .reset(reset), .avs(u_if2.slave), .irq(irq2), .irq_any(irq_any2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          rg;
        bit          wr;
        logic [15:0] data;
        bit          chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int ch, int rg, bit wr, logic [15:0] data, bit chk, logic [15:0] exp);
        vec_t v;
        v.ch = ch; v.rg = rg; v.wr = wr; v.data = data; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle on the 4-channel instance; returns at 1 time unit after the edge.
    task automatic bus1(input int ch, input int rg, input bit we, input logic [15:0] d);
        u_if.address    = 5'(ch * 8 + rg);
        u_if.chipselect = we;
        u_if.write_n    = !we;
        u_if.writedata  = d;
        @(posedge clk); #1;
        u_if.chipselect = 1'b0;
        u_if.write_n    = 1'b1;
    endtask

    task automatic wr1(input int ch, input int rg, input logic [15:0] d);
        bus1(ch, rg, 1'b1, d);
    endtask

    task automatic rd1(input int ch, input int rg, output logic [15:0] v);
        bus1(ch, rg, 1'b0, 16'h0);
        v = u_if.readdata;
    endtask

    task automatic bus2(input int ch, input int rg, input bit we, input logic [15:0] d, output logic [15:0] v);
        u_if2.address    = 5'(ch * 8 + rg);
        u_if2.chipselect = we;
        u_if2.write_n    = !we;
        u_if2.writedata  = d;
        @(posedge clk); #1;
        u_if2.chipselect = 1'b0;
        u_if2.write_n    = 1'b1;
        v = u_if2.readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Number of edges until irq[idx] is seen high, or -1 if the budget runs out.
    task automatic wait_irq(input int idx, input int max_cyc, output int k);
        bit found = 1'b0;
        k = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            if (!found) begin
                @(posedge clk); #1;
                if (irq[idx]) begin
                    k = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] first_rd;
        int          k;
        int          first;

        u_if.address = '0; u_if.chipselect = 1'b0; u_if.write_n = 1'b1; u_if.writedata = '0;
        u_if2.address = '0; u_if2.chipselect = 1'b0; u_if2.write_n = 1'b1; u_if2.writedata = '0;

        // Reset state, then time to the first ch0 timeout with period 49.
        repeat (3) begin @(posedge clk); #1; end
        check("reset readdata", 32'(u_if.readdata), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset irq_any", 32'(irq_any), 32'h0);
        reset = 1'b0;

        first = -1;
        first_rd = 16'hxxxx;
        for (int i = 1; i <= 120; i++) begin
            if (first < 0) begin
                @(posedge clk); #1;
                if (i == 1) first_rd = u_if.readdata;
                if (u_if.readdata[ST_TO]) first = i;
            end
        end
        check("ch0 status after reset", 32'(first_rd), 32'h2);
        // TO sets at edge 50; the registered read shows it one edge later.
        check("ch0 first TO edge", 32'(first), 32'd51);
        check("irq masked by ITO=0", 32'(irq), 32'h0);
        wr1(0, REG_CONTROL, 16'h0003);
        check("ch0 irq after ITO=1", 32'(irq), 32'h1);
        check("irq_any after ITO=1", 32'(irq_any), 32'h1);
        wr1(0, REG_CONTROL, 16'h0008);
        wr1(0, REG_STATUS, 16'h0000);
        check("irq after ch0 stop+clear", 32'(irq), 32'h0);

        // Ch1 continuous period 4: event every 5 clks; clear coinciding with an event.
        wr1(1, REG_PERIODL, 16'd4);
        wr1(1, REG_PERIODH, 16'd0);
        wr1(1, REG_STATUS, 16'h0);
        wr1(1, REG_CONTROL, 16'h0007);
        wait_irq(1, 20, k);
        check("ch1 first event latency", 32'(k), 32'd5);
        wr1(1, REG_STATUS, 16'h0);
        check("ch1 TO cleared", 32'(irq[1]), 32'h0);
        idle(3);
        check("ch1 no early event", 32'(irq[1]), 32'h0);
        idle(1);
        check("ch1 second event", 32'(irq[1]), 32'h1);
        idle(4);
        wr1(1, REG_STATUS, 16'h0);
        check("ch1 clear vs event irq", 32'(irq[1]), 32'h1);
        rd1(1, REG_STATUS, v);
        check("ch1 clear vs event STATUS", 32'(v), 32'h3);
        wr1(1, REG_CONTROL, 16'h0008);
        wr1(1, REG_STATUS, 16'h0);

        // Ch2 one-shot period 3: single event after 4 clks, then holds 3.
        wr1(2, REG_PERIODL, 16'd3);
        wr1(2, REG_PERIODH, 16'd0);
        wr1(2, REG_STATUS, 16'h0);
        wr1(2, REG_CONTROL, 16'h0005);
        wait_irq(2, 20, k);
        check("ch2 one-shot latency", 32'(k), 32'd4);
        wr1(2, REG_STATUS, 16'h0);
        idle(8);
        check("ch2 no second event", 32'(irq[2]), 32'h0);
        rd1(2, REG_STATUS, v);
        check("ch2 stopped status", 32'(v), 32'h0);
        wr1(2, REG_SNAPL, 16'h0);
        rd1(2, REG_SNAPL, v);
        check("ch2 held counter L", 32'(v), 32'h3);
        rd1(2, REG_SNAPH, v);
        check("ch2 held counter H", 32'(v), 32'h0);

        // Table: period write mid-count (ch1), STOP|START and snapshot (ch3), reserved regs.
        vecs.push_back(mk(1, REG_PERIODL, 1, 16'h0010, 0, 16'h0));
        vecs.push_back(mk(1, REG_CONTROL, 1, 16'h0006, 0, 16'h0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, REG_STATUS, 0, 16'h0, 1, 16'h0002));
        vecs.push_back(mk(1, REG_PERIODH, 1, 16'h0005, 0, 16'h0));
        vecs.push_back(mk(1, REG_STATUS,  0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(1, REG_SNAPL,   1, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, REG_SNAPL,   0, 16'h0, 1, 16'h0010));
        vecs.push_back(mk(1, REG_SNAPH,   0, 16'h0, 1, 16'h0005));
        vecs.push_back(mk(3, REG_PERIODL, 1, 16'h1234, 0, 16'h0));
        vecs.push_back(mk(3, REG_PERIODH, 1, 16'h0002, 0, 16'h0));
        vecs.push_back(mk(3, REG_STATUS,  1, 16'h0, 0, 16'h0));
        vecs.push_back(mk(3, REG_PERIODL, 0, 16'h0, 1, 16'h1234));
        vecs.push_back(mk(3, REG_PERIODH, 0, 16'h0, 1, 16'h0002));
        vecs.push_back(mk(3, REG_STATUS,  0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(3, REG_CONTROL, 1, 16'h0006, 0, 16'h0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(3, REG_STATUS, 0, 16'h0, 1, 16'h0002));
        vecs.push_back(mk(3, REG_CONTROL, 0, 16'h0, 1, 16'h0002));
        // Tenth edge after START: counter 0x21234 - 10.
        vecs.push_back(mk(3, REG_CONTROL, 1, 16'h000C, 0, 16'h0));
        vecs.push_back(mk(3, REG_STATUS,  0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(3, REG_CONTROL, 0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(3, REG_SNAPL,   1, 16'h0, 0, 16'h0));
        vecs.push_back(mk(3, REG_SNAPL,   0, 16'h0, 1, 16'h122A));
        vecs.push_back(mk(3, REG_SNAPH,   0, 16'h0, 1, 16'h0002));
        vecs.push_back(mk(3, REG_SNAPL,   1, 16'h0, 0, 16'h0));
        vecs.push_back(mk(3, REG_SNAPL,   0, 16'h0, 1, 16'h122A));
        vecs.push_back(mk(3, 6, 0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(3, 7, 0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(3, 7, 1, 16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3, 6, 1, 16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3, REG_PERIODL, 0, 16'h0, 1, 16'h1234));
        vecs.push_back(mk(3, REG_STATUS,  0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(3, REG_CONTROL, 0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(3, REG_SNAPL,   0, 16'h0, 1, 16'h122A));

        for (int i = 0; i < vecs.size(); i++) begin
            bus1(vecs[i].ch, vecs[i].rg, vecs[i].wr, vecs[i].data);
            if (vecs[i].chk)
                check($sformatf("vec%0d ch%0d reg%0d", i, vecs[i].ch, vecs[i].rg),
                      32'(u_if.readdata), 32'(vecs[i].exp));
        end

        // Two channels pending: irq_any holds until both are cleared.
        wr1(0, REG_PERIODL, 16'd2);
        wr1(0, REG_PERIODH, 16'd0);
        wr1(0, REG_CONTROL, 16'h0005);
        wr1(2, REG_CONTROL, 16'h0005);
        idle(6);
        check("two pending irq", 32'(irq), 32'h5);
        check("two pending irq_any", 32'(irq_any), 32'h1);
        wr1(0, REG_STATUS, 16'h0);
        check("one cleared irq", 32'(irq), 32'h4);
        check("one cleared irq_any", 32'(irq_any), 32'h1);
        wr1(2, REG_STATUS, 16'h0);
        check("both cleared irq_any", 32'(irq_any), 32'h0);

        // Reset in the middle of activity.
        wr1(2, REG_CONTROL, 16'h0005);
        idle(6);
        check("ch2 retrigger irq", 32'(irq), 32'h4);
        rd1(3, REG_PERIODL, v);
        check("pre-reset readdata", 32'(v), 32'h1234);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid reset readdata", 32'(u_if.readdata), 32'h0);
        check("mid reset irq", 32'(irq), 32'h0);
        check("mid reset irq_any", 32'(irq_any), 32'h0);
        reset = 1'b0;
        rd1(3, REG_PERIODL, v);  check("post reset PERIODL", 32'(v), 32'h0031);
        rd1(3, REG_PERIODH, v);  check("post reset PERIODH", 32'(v), 32'h0000);
        rd1(3, REG_CONTROL, v);  check("post reset CONTROL", 32'(v), 32'h0002);
        rd1(3, REG_STATUS, v);   check("post reset STATUS", 32'(v), 32'h0002);
        rd1(3, REG_SNAPL, v);    check("post reset SNAPL", 32'(v), 32'h0000);
        rd1(2, REG_CONTROL, v);  check("post reset ch2 CONTROL", 32'(v), 32'h0002);

        // 3-channel, 20-bit instance: unmapped channel 3 and truncated PERIODH.
        bus2(0, REG_PERIODL, 0, 16'h0, v); check("w20 default PERIODL", 32'(v), 32'h869F);
        bus2(0, REG_PERIODH, 0, 16'h0, v); check("w20 default PERIODH", 32'(v), 32'h0001);
        bus2(0, REG_PERIODH, 1, 16'hFFFF, v);
        bus2(0, REG_PERIODH, 0, 16'h0, v); check("w20 PERIODH truncated", 32'(v), 32'h000F);
        bus2(0, REG_PERIODL, 0, 16'h0, v); check("w20 PERIODL kept", 32'(v), 32'h869F);
        bus2(3, REG_STATUS, 0, 16'h0, v);  check("unmapped ch STATUS", 32'(v), 32'h0);
        bus2(3, REG_PERIODL, 1, 16'hAAAA, v);
        bus2(3, REG_PERIODL, 0, 16'h0, v); check("unmapped ch PERIODL", 32'(v), 32'h0);
        bus2(1, REG_PERIODL, 0, 16'h0, v); check("w20 ch1 PERIODL untouched", 32'(v), 32'h869F);
        bus2(1, REG_STATUS, 0, 16'h0, v);  check("w20 ch1 still running", 32'(v), 32'h0002);
        bus2(0, REG_STATUS, 0, 16'h0, v);  check("w20 ch0 stopped by PERIODH", 32'(v), 32'h0000);
        check("w20 irq_any", 32'(irq_any2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
